// File: rtl/axil_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_rr_arbiter_if
// Description : AXI4-Lite channel bundle (AW/W/B/AR/R) used on every port
//               of the two-master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_rr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    // Initiator side: drives addresses, write data and response readies.
    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    // Target side: drives readies and responses.
    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axil_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axil_rr_arbiter
// Description : Two-master to one-slave AXI4-Lite arbiter. One complete
//               transaction per grant, round-robin between masters, write
//               before read. Define ARB_FIXED_PRIO_EN for fixed m0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic          sysclk,
    input  wire logic          rst,
    axil_rr_arbiter_if.slave   m0,
    axil_rr_arbiter_if.slave   m1,
    axil_rr_arbiter_if.master  s,
    output logic [1:0]         grant,
    output logic               busy
);

    localparam int          c_STRB_W = DATA_W / 8;
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_WR     = 2'd1;
    localparam logic [1:0]  S_RD     = 2'd2;

    logic [1:0]             r_state;
    logic                   r_owner;
    logic [1:0]             r_grant;
    logic                   r_busy;
`ifndef ARB_FIXED_PRIO_EN
    logic                   r_last;
`endif

    logic                   w_req0;
    logic                   w_req1;
    logic                   w_pick;
    logic                   w_pick_aw;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_src;

    logic                   w_awvalid;
    logic [ADDR_W-1:0]      w_awaddr;
    logic [2:0]             w_awprot;
    logic                   w_wvalid;
    logic [DATA_W-1:0]      w_wdata;
    logic [c_STRB_W-1:0]    w_wstrb;
    logic                   w_bready;
    logic                   w_arvalid;
    logic [ADDR_W-1:0]      w_araddr;
    logic [2:0]             w_arprot;
    logic                   w_rready;

    // ------------------------------------------------------------------
    // Arbitration decision, evaluated only while idle
    // ------------------------------------------------------------------
    assign w_req0 = m0.awvalid | m0.arvalid;
    assign w_req1 = m1.awvalid | m1.arvalid;

    always_comb begin
        w_pick = 1'b0;
        if (w_req0 && w_req1) begin
`ifdef ARB_FIXED_PRIO_EN
            w_pick = 1'b0;
`else
            w_pick = ~r_last;
`endif
        end else if (w_req1) begin
            w_pick = 1'b1;
        end
    end

    assign w_pick_aw = w_pick ? m1.awvalid : m0.awvalid;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            r_last  <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_owner <= w_pick;
                        r_state <= w_pick_aw ? S_WR : S_RD;
                        r_grant <= w_pick ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                    end
                end
                S_WR: begin
                    if (s.bvalid && w_bready) begin
`ifndef ARB_FIXED_PRIO_EN
                        r_last  <= r_owner;
`endif
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                    end
                end
                S_RD: begin
                    if (s.rvalid && w_rready) begin
`ifndef ARB_FIXED_PRIO_EN
                        r_last  <= r_owner;
`endif
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;

    // ------------------------------------------------------------------
    // Channel routing; source falls back to m0 while idle
    // ------------------------------------------------------------------
    assign w_wr  = (r_state == S_WR);
    assign w_rd  = (r_state == S_RD);
    assign w_src = r_owner & (r_state != S_IDLE);

    assign w_awvalid = w_src ? m1.awvalid : m0.awvalid;
    assign w_awaddr  = w_src ? m1.awaddr  : m0.awaddr;
    assign w_awprot  = w_src ? m1.awprot  : m0.awprot;
    assign w_wvalid  = w_src ? m1.wvalid  : m0.wvalid;
    assign w_wdata   = w_src ? m1.wdata   : m0.wdata;
    assign w_wstrb   = w_src ? m1.wstrb   : m0.wstrb;
    assign w_bready  = w_src ? m1.bready  : m0.bready;
    assign w_arvalid = w_src ? m1.arvalid : m0.arvalid;
    assign w_araddr  = w_src ? m1.araddr  : m0.araddr;
    assign w_arprot  = w_src ? m1.arprot  : m0.arprot;
    assign w_rready  = w_src ? m1.rready  : m0.rready;

    assign s.awvalid = w_wr & w_awvalid;
    assign s.awaddr  = w_awaddr;
    assign s.awprot  = w_awprot;
    assign s.wvalid  = w_wr & w_wvalid;
    assign s.wdata   = w_wdata;
    assign s.wstrb   = w_wstrb;
    assign s.bready  = w_wr & w_bready;
    assign s.arvalid = w_rd & w_arvalid;
    assign s.araddr  = w_araddr;
    assign s.arprot  = w_arprot;
    assign s.rready  = w_rd & w_rready;

    // Only the owner ever sees ready/valid from the slave.
    assign m0.awready = w_wr & ~r_owner & s.awready;
    assign m0.wready  = w_wr & ~r_owner & s.wready;
    assign m0.bvalid  = w_wr & ~r_owner & s.bvalid;
    assign m0.bresp   = s.bresp;
    assign m0.arready = w_rd & ~r_owner & s.arready;
    assign m0.rvalid  = w_rd & ~r_owner & s.rvalid;
    assign m0.rdata   = s.rdata;
    assign m0.rresp   = s.rresp;

    assign m1.awready = w_wr & r_owner & s.awready;
    assign m1.wready  = w_wr & r_owner & s.wready;
    assign m1.bvalid  = w_wr & r_owner & s.bvalid;
    assign m1.bresp   = s.bresp;
    assign m1.arready = w_rd & r_owner & s.arready;
    assign m1.rvalid  = w_rd & r_owner & s.rvalid;
    assign m1.rdata   = s.rdata;
    assign m1.rresp   = s.rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_rr_arbiter
// Description : Self-checking bench for axil_rr_arbiter: arbitration vector
//               table plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_rr_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic [1:0] grant;
    logic       busy;

    axil_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    axil_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    axil_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    axil_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if),
        .grant  (grant),
        .busy   (busy)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        m0aw;
        logic        m0ar;
        logic        m1aw;
        logic        m1ar;
        logic [1:0]  exp_grant;
        logic        exp_aw;
        logic        exp_ar;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t       vecs [9];
    logic [1:0] exp_rr [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge sysclk);
    endtask

    task automatic clear_inputs();
        m0_if.awvalid = 0; m0_if.wvalid = 0; m0_if.bready = 0; m0_if.arvalid = 0; m0_if.rready = 0;
        m1_if.awvalid = 0; m1_if.wvalid = 0; m1_if.bready = 0; m1_if.arvalid = 0; m1_if.rready = 0;
        m0_if.awaddr = 32'h100; m0_if.araddr = 32'h300; m0_if.wdata = 32'h0; m0_if.wstrb = 4'hf;
        m1_if.awaddr = 32'h200; m1_if.araddr = 32'h400; m1_if.wdata = 32'h0; m1_if.wstrb = 4'hf;
        m0_if.awprot = 3'd0; m0_if.arprot = 3'd0; m1_if.awprot = 3'd0; m1_if.arprot = 3'd0;
        s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = 2'd0;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = 32'h0; s_if.rresp = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //               m0aw m0ar m1aw m1ar grant  aw   ar   addr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h100};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 32'h300};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h200};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h400};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 32'h200};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h300};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h300};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h100};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0};
`ifdef ARB_FIXED_PRIO_EN
        exp_rr = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        clear_inputs();
        step();

        // Reset state with everything that could leak through held high
        rst = 1'b1;
        m0_if.bready = 1; m0_if.rready = 1; m1_if.bready = 1; m1_if.rready = 1;
        s_if.awready = 1; s_if.wready = 1; s_if.arready = 1; s_if.bvalid = 1; s_if.rvalid = 1;
        step();
        step();
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_valid_ready", {s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready, s_if.rready}, 5'b0);
        chk("rst_m0_ready_valid", {m0_if.awready, m0_if.wready, m0_if.arready, m0_if.bvalid, m0_if.rvalid}, 5'b0);
        chk("rst_m1_ready_valid", {m1_if.awready, m1_if.wready, m1_if.arready, m1_if.bvalid, m1_if.rvalid}, 5'b0);

        // Arbitration table, each vector from a fresh reset (last = m1)
        for (int i = 0; i < 9; i++) begin
            do_reset();
            m0_if.awvalid = vecs[i].m0aw; m0_if.arvalid = vecs[i].m0ar;
            m1_if.awvalid = vecs[i].m1aw; m1_if.arvalid = vecs[i].m1ar;
            #1;
            chk("vec_latency", {s_if.awvalid, s_if.arvalid}, 2'b00);
            step();
            chk("vec_grant", grant, vecs[i].exp_grant);
            chk("vec_busy", busy, (vecs[i].exp_grant != 2'b00));
            chk("vec_s_awvalid", s_if.awvalid, vecs[i].exp_aw);
            chk("vec_s_arvalid", s_if.arvalid, vecs[i].exp_ar);
            if (vecs[i].exp_grant != 2'b00)
                chk("vec_addr", vecs[i].exp_aw ? s_if.awaddr : s_if.araddr, vecs[i].exp_addr);
        end

        // m0 single write, slave always ready
        do_reset();
        s_if.awready = 1; s_if.wready = 1;
        m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.awaddr = 32'h0; m0_if.wdata = 32'h1; m0_if.bready = 1;
        #1;
        chk("wr_idle_awvalid", s_if.awvalid, 1'b0);
        chk("wr_idle_awready", m0_if.awready, 1'b0);
        step();
        chk("wr_grant", grant, 2'b01);
        chk("wr_busy", busy, 1'b1);
        chk("wr_s_aw_w", {s_if.awvalid, s_if.wvalid}, 2'b11);
        chk("wr_m0_ready", {m0_if.awready, m0_if.wready}, 2'b11);
        chk("wr_wdata", s_if.wdata, 32'h1);
        chk("wr_m1_ready", {m1_if.awready, m1_if.wready}, 2'b00);
        step();
        m0_if.awvalid = 0; m0_if.wvalid = 0;
        s_if.bvalid = 1; s_if.bresp = 2'd0;
        #1;
        chk("wr_m0_bvalid", m0_if.bvalid, 1'b1);
        chk("wr_m0_bresp", m0_if.bresp, 2'd0);
        chk("wr_m1_bvalid", m1_if.bvalid, 1'b0);
        chk("wr_s_bready", s_if.bready, 1'b1);
        step();
        s_if.bvalid = 0;
        chk("wr_done_busy", busy, 1'b0);
        chk("wr_done_grant", grant, 2'b00);

        // Both masters hammer reads
        do_reset();
        s_if.arready = 1;
        m0_if.arvalid = 1; m0_if.rready = 1; m1_if.arvalid = 1; m1_if.rready = 1;
        for (int t = 0; t < 4; t++) begin
            int waited;
            waited = 0;
            while (!busy && waited < 5) begin
                step();
                waited++;
            end
            chk("rr_wait", busy, 1'b1);
            chk("rr_grant", grant, exp_rr[t]);
            step();
            s_if.rvalid = 1;
            step();
            chk("rr_idle_gap", busy, 1'b0);
            s_if.rvalid = 0;
        end

        // m1 write and read requested together
        do_reset();
        s_if.awready = 1; s_if.wready = 1; s_if.arready = 1;
        m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.bready = 1; m1_if.arvalid = 1; m1_if.rready = 1;
        step();
        chk("wa_grant_wr", grant, 2'b10);
        chk("wa_s_aw_ar", {s_if.awvalid, s_if.arvalid}, 2'b10);
        step();
        m1_if.awvalid = 0; m1_if.wvalid = 0;
        s_if.bvalid = 1;
        step();
        s_if.bvalid = 0;
        chk("wa_gap_busy", busy, 1'b0);
        chk("wa_gap_arready", m1_if.arready, 1'b0);
        step();
        chk("wa_grant_rd", grant, 2'b10);
        chk("wa_s_aw_ar_rd", {s_if.awvalid, s_if.arvalid}, 2'b01);
        chk("wa_araddr", s_if.araddr, 32'h400);
        step();
        m1_if.arvalid = 0;
        s_if.rvalid = 1;
        step();
        chk("wa_rd_done_rvalid", m1_if.rvalid, 1'b0);
        chk("wa_rd_done_busy", busy, 1'b0);
        s_if.rvalid = 0;

        // Write-data stall with m1 waiting
        do_reset();
        s_if.awready = 1; s_if.wready = 0;
        m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.awaddr = 32'h10; m0_if.wdata = 32'h55; m0_if.bready = 1;
        m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.awaddr = 32'h20; m1_if.bready = 1;
        step();
        chk("stall_grant0", grant, 2'b01);
        chk("stall_awaddr0", s_if.awaddr, 32'h10);
        step();
        m0_if.awvalid = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stall_grant", grant, 2'b01);
            chk("stall_m1_awready", m1_if.awready, 1'b0);
            chk("stall_m0_wready", m0_if.wready, 1'b0);
            step();
        end
        s_if.wready = 1;
        step();
        m0_if.wvalid = 0;
        s_if.bvalid = 1;
        #1;
        chk("stall_m0_bvalid", m0_if.bvalid, 1'b1);
        chk("stall_m1_bvalid", m1_if.bvalid, 1'b0);
        step();
        s_if.bvalid = 0;
        chk("stall_gap_grant", grant, 2'b00);
        step();
        chk("stall_m1_grant", grant, 2'b10);
        chk("stall_m1_awready_on", m1_if.awready, 1'b1);
        chk("stall_m1_awaddr", s_if.awaddr, 32'h20);

        // Reset while a read response is pending
        do_reset();
        s_if.arready = 1;
        m0_if.arvalid = 1; m0_if.rready = 1;
        step();
        chk("rrst_grant", grant, 2'b01);
        step();
        m0_if.arvalid = 0;
        s_if.rvalid = 1;
        #1;
        chk("rrst_rvalid_pending", m0_if.rvalid, 1'b1);
        rst = 1'b1;
        step();
        chk("rrst_grant_after", grant, 2'b00);
        chk("rrst_busy_after", busy, 1'b0);
        chk("rrst_rvalid_after", m0_if.rvalid, 1'b0);
        rst = 1'b0;
        s_if.rvalid = 0;
        m0_if.arvalid = 1;
        step();
        chk("rrst_fresh_grant", grant, 2'b01);
        chk("rrst_fresh_arvalid", s_if.arvalid, 1'b1);
        step();
        m0_if.arvalid = 0;
        s_if.rvalid = 1; s_if.rdata = 32'hcafe; s_if.rresp = 2'd0;
        #1;
        chk("rrst_fresh_rvalid", m0_if.rvalid, 1'b1);
        chk("rrst_fresh_rdata", m0_if.rdata, 32'hcafe);
        step();
        s_if.rvalid = 0;
        chk("rrst_fresh_done", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
